// File: rtl/wu_seq_if.sv
// Control bundle between the weight-update sequencer and its surroundings.
//   master : drives start/num_rows/base_addr, observes the sequencer outputs
//   slave  : the sequencer itself
// Signals:
//   start     single-cycle pass request
//   num_rows  rows to process (addrWidth+1 bits, values above 2^addrWidth clamp)
//   base_addr first row address
//   rd_en/rd_addr   read strobe and row address to the weight/gradient buffers
//   sub_en          subtract-stage enable, aligned with read data
//   wr_en/wr_addr   write-back strobe and row address, aligned with the result
//   busy/done       pass in progress / one-cycle completion pulse
interface wu_seq_if #(
  parameter int unsigned addrWidth = 8
);
  logic                 start;
  logic [addrWidth:0]   num_rows;
  logic [addrWidth-1:0] base_addr;
  logic                 rd_en;
  logic [addrWidth-1:0] rd_addr;
  logic                 sub_en;
  logic                 wr_en;
  logic [addrWidth-1:0] wr_addr;
  logic                 busy;
  logic                 done;

  modport master (
    output start, num_rows, base_addr,
    input  rd_en, rd_addr, sub_en, wr_en, wr_addr, busy, done
  );

  modport slave (
    input  start, num_rows, base_addr,
    output rd_en, rd_addr, sub_en, wr_en, wr_addr, busy, done
  );
endinterface

// File: rtl/wu_seq.sv
// Weight-update sequencer: walks num_rows rows starting at base_addr, one read per
// cycle, and produces a subtract enable and a latency-matched write-back strobe and
// address. Carries control only; the subtract stage output is the write data.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset; aborts any pass in flight
//   bus  wu_seq_if.slave control bundle (see interface header)
module wu_seq #(
  parameter int unsigned dataWidth   = 32,
  parameter int unsigned pactivation = 16,
  parameter int unsigned addrWidth   = 8,
  parameter int unsigned rdLatency   = 1,
  parameter int unsigned subLatency  = 11
) (
  input logic   clk,
  input logic   rst,
  wu_seq_if.slave bus
);

  if (dataWidth == 0 || pactivation == 0 || rdLatency == 0 || subLatency == 0) begin : gBadParam
    $error("wu_seq: dataWidth, pactivation, rdLatency and subLatency must be >= 1");
  end

  localparam int unsigned Lat = rdLatency + subLatency;
  localparam logic [addrWidth:0] MaxRows = {1'b1, {addrWidth{1'b0}}};
  localparam logic [addrWidth:0] CntOne  = 1;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e               stateQ, stateD;
  logic [addrWidth:0]   rowsQ;
  logic [addrWidth:0]   cntQ;
  logic [addrWidth-1:0] baseQ;
  logic [addrWidth:0]   rowsClamped;
  logic                 rdEn;
  logic [addrWidth-1:0] rdAddr;

  // validQ[i] is rd_en delayed by i+1 cycles; addrQ carries the matching row address.
  logic [Lat-1:0]       validQ;
  logic [addrWidth-1:0] addrQ [Lat];

  assign rowsClamped = (bus.num_rows > MaxRows) ? MaxRows : bus.num_rows;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  // Pass parameters and issue counter
  always_ff @(posedge clk) begin
    if (rst) begin
      rowsQ <= '0;
      cntQ  <= '0;
      baseQ <= '0;
    end else if (stateQ == StIdle && bus.start) begin
      rowsQ <= rowsClamped;
      baseQ <= bus.base_addr;
      cntQ  <= '0;
    end else if (stateQ == StIssue) begin
      cntQ <= cntQ + CntOne;
    end
  end

  // Valid/address delay lines; shifting (not counting) keeps any gaps exact.
  always_ff @(posedge clk) begin
    if (rst) begin
      validQ <= '0;
      for (int i = 0; i < Lat; i++) begin
        addrQ[i] <= '0;
      end
    end else begin
      validQ   <= {validQ[Lat-2:0], rdEn};
      addrQ[0] <= rdAddr;
      for (int i = 1; i < Lat; i++) begin
        addrQ[i] <= addrQ[i-1];
      end
    end
  end

  // Next-state logic
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle: begin
        if (bus.start) begin
          stateD = (bus.num_rows == '0) ? StDone : StIssue;
        end
      end
      StIssue: begin
        if (cntQ == rowsQ - CntOne) begin
          stateD = StDrain;
        end
      end
      StDrain: begin
        // Rows are issued contiguously, so once only the output stage holds a token
        // the last write-back is on the bus this cycle.
        if (validQ[Lat-2:0] == '0) begin
          stateD = StDone;
        end
      end
      StDone: begin
        stateD = StIdle;
      end
      default: begin
        stateD = StIdle;
      end
    endcase
  end

  // Outputs
  always_comb begin
    rdEn        = (stateQ == StIssue);
    rdAddr      = rdEn ? (baseQ + cntQ[addrWidth-1:0]) : '0;
    bus.rd_en   = rdEn;
    bus.rd_addr = rdAddr;
    bus.sub_en  = validQ[rdLatency-1];
    bus.wr_en   = validQ[Lat-1];
    bus.wr_addr = addrQ[Lat-1];
    bus.busy    = (stateQ == StIssue) || (stateQ == StDrain);
    bus.done    = (stateQ == StDone);
  end

endmodule

// File: tb/tb_wu_seq.sv
module tb_wu_seq;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  wu_seq_if #(.addrWidth(8)) bus0 ();
  wu_seq_if #(.addrWidth(8)) bus1 ();

  wu_seq #(
    .dataWidth(32), .pactivation(16), .addrWidth(8), .rdLatency(1), .subLatency(11)
  ) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  wu_seq #(
    .dataWidth(32), .pactivation(16), .addrWidth(8), .rdLatency(2), .subLatency(5)
  ) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  // Reference model: a pass is fully described by its start cycle, row count and base.
  int latR [2] = '{1, 2};
  int latS [2] = '{11, 5};
  bit actM [2];
  int sM   [2];
  int nM   [2];
  int baseM[2];
  bit rstPrev;

  task automatic chk(input string name, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", name, d, cyc, act, exp);
    end
  endtask

  function automatic int doneCycle(input int d);
    if (nM[d] == 0) return sM[d] + 1;
    return sM[d] + nM[d] + latR[d] + latS[d] + 1;
  endfunction

  function automatic bit idleAt(input int d);
    return !actM[d] || (cyc > doneCycle(d));
  endfunction

  task automatic checkDut(input int d, input logic rdEn, input logic [7:0] rdAddr,
                          input logic subEn, input logic wrEn, input logic [7:0] wrAddr,
                          input logic busy, input logic done);
    int  k, lat, n;
    bit  eRd, eSub, eWr, eBusy, eDone;
    lat = latR[d] + latS[d];
    n   = nM[d];
    k   = cyc - sM[d];
    eRd = 0; eSub = 0; eWr = 0; eBusy = 0; eDone = 0;
    if (actM[d]) begin
      eRd   = (n > 0) && (k >= 1) && (k <= n);
      eSub  = (n > 0) && (k - latR[d] >= 1) && (k - latR[d] <= n);
      eWr   = (n > 0) && (k - lat >= 1) && (k - lat <= n);
      eBusy = (n > 0) && (k >= 1) && (k <= n + lat);
      eDone = (k == doneCycle(d) - sM[d]);
    end
    chk("rd_en", d, 32'(rdEn), 32'(eRd));
    chk("sub_en", d, 32'(subEn), 32'(eSub));
    chk("wr_en", d, 32'(wrEn), 32'(eWr));
    chk("busy", d, 32'(busy), 32'(eBusy));
    chk("done", d, 32'(done), 32'(eDone));
    if (eRd) chk("rd_addr", d, 32'(rdAddr), 32'((baseM[d] + k - 1) & 255));
    if (eWr) chk("wr_addr", d, 32'(wrAddr), 32'((baseM[d] + k - lat - 1) & 255));
    if (rstPrev) begin
      chk("rst_rd_addr", d, 32'(rdAddr), 32'd0);
      chk("rst_wr_addr", d, 32'(wrAddr), 32'd0);
    end
  endtask

  initial begin
    bit rS, sS;
    int nS, bS, r;
    rst = 1'b1;
    bus0.start = 1'b0; bus0.num_rows = '0; bus0.base_addr = '0;
    bus1.start = 1'b0; bus1.num_rows = '0; bus1.base_addr = '0;
    rstPrev = 1'b1;
    for (int d = 0; d < 2; d++) begin
      actM[d] = 0; sM[d] = 0; nM[d] = 0; baseM[d] = 0;
    end

    while (cyc < 3500) begin
      @(negedge clk);
      checkDut(0, bus0.rd_en, bus0.rd_addr, bus0.sub_en, bus0.wr_en, bus0.wr_addr,
               bus0.busy, bus0.done);
      checkDut(1, bus1.rd_en, bus1.rd_addr, bus1.sub_en, bus1.wr_en, bus1.wr_addr,
               bus1.busy, bus1.done);

      // Hand-computed expectations that pin the model.
      if (cyc == 6)   chk("lit_rd_addr_first", 0, 32'(bus0.rd_addr), 32'h10);
      if (cyc == 7)   chk("lit_sub_en", 0, 32'(bus0.sub_en), 32'd1);
      if (cyc == 18)  chk("lit_wr_first", 0, {bus0.wr_en, bus0.wr_addr}, 32'h110);
      if (cyc == 21)  chk("lit_wr_last", 0, {bus0.wr_en, bus0.wr_addr}, 32'h113);
      if (cyc == 21)  chk("lit_busy_end", 0, 32'(bus0.busy), 32'd1);
      if (cyc == 22)  chk("lit_done", 0, {bus0.done, bus0.busy}, 32'h2);
      if (cyc == 31)  chk("lit_zero_done", 0, {bus0.done, bus0.busy, bus0.rd_en}, 32'h4);
      if (cyc == 31)  chk("lit_zero_done", 1, {bus1.done, bus1.busy, bus1.rd_en}, 32'h4);
      if (cyc == 37)  chk("lit_sub_early", 1, 32'(bus1.sub_en), 32'd0);
      if (cyc == 38)  chk("lit_sub_first", 1, 32'(bus1.sub_en), 32'd1);
      if (cyc == 38)  chk("lit_wrap_rd", 0, {bus0.rd_en, bus0.rd_addr}, 32'h100);
      if (cyc == 43)  chk("lit_wr_first", 1, {bus1.wr_en, bus1.wr_addr}, 32'h1FE);
      if (cyc == 45)  chk("lit_wr_last", 1, {bus1.wr_en, bus1.wr_addr}, 32'h100);
      if (cyc == 46)  chk("lit_done", 1, 32'(bus1.done), 32'd1);
      if (cyc == 48)  chk("lit_wrap_wr", 0, {bus0.wr_en, bus0.wr_addr}, 32'h1FE);
      if (cyc == 51)  chk("lit_done", 0, 32'(bus0.done), 32'd1);
      if (cyc == 316) chk("lit_rd_256_last", 0, {bus0.rd_en, bus0.rd_addr}, 32'h132);
      if (cyc == 317) chk("lit_rd_256_off", 0, 32'(bus0.rd_en), 32'd0);
      if (cyc == 324) chk("lit_done_256", 1, 32'(bus1.done), 32'd1);
      if (cyc == 329) chk("lit_done_256", 0, 32'(bus0.done), 32'd1);
      if (cyc == 346) chk("lit_busy_pre_rst", 0, 32'(bus0.busy), 32'd1);
      if (cyc == 347) chk("lit_after_rst", 0, {bus0.busy, bus0.rd_en, bus0.done}, 32'd0);
      if (cyc == 349) chk("lit_restart", 0, {bus0.rd_en, bus0.rd_addr}, 32'h180);
      if (cyc == 366) chk("lit_restart_done", 0, 32'(bus0.done), 32'd1);

      rS = 0; sS = 0; nS = 0; bS = 0;
      if (cyc < 3) rS = 1;
      else if (cyc < 400) begin
        case (cyc)
          5:   begin sS = 1; nS = 4;   bS = 'h10; end
          30:  begin sS = 1; nS = 0;   bS = 'h55; end
          35:  begin sS = 1; nS = 3;   bS = 'hFE; end
          60:  begin sS = 1; nS = 256; bS = 'h33; end
          100: begin sS = 1; nS = 5;   bS = 'h00; end
          340: begin sS = 1; nS = 10;  bS = 'h00; end
          346: rS = 1;
          348: begin sS = 1; nS = 5;   bS = 'h80; end
          default: ;
        endcase
      end else begin
        rS = ($urandom_range(0, 249) == 0);
        sS = ($urandom_range(0, 5) == 0);
        r  = $urandom_range(0, 9);
        if (r == 0) nS = 0;
        else if (r == 1) nS = $urandom_range(0, 511);
        else nS = $urandom_range(1, 20);
        bS = $urandom_range(0, 255);
      end

      rst = rS;
      bus0.start = sS; bus0.num_rows = 9'(nS); bus0.base_addr = 8'(bS);
      bus1.start = sS; bus1.num_rows = 9'(nS); bus1.base_addr = 8'(bS);

      for (int d = 0; d < 2; d++) begin
        if (rS) begin
          actM[d] = 0;
        end else if (sS && idleAt(d)) begin
          actM[d]  = 1;
          sM[d]    = cyc;
          nM[d]    = (nS > 256) ? 256 : nS;
          baseM[d] = bS;
        end
      end
      rstPrev = rS;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
